// File: rtl/seg7_scan4.sv
// ---------------------------------------------------------------------------
// seg7_scan4
//
// Drives a multiplexed 4-digit common-anode 7-segment display from four BCD
// digits. New digit values are held in a pending buffer and only move into
// the display register on a frame boundary, so a frame never shows a mix of
// old and new digits.
//
// Parameters:
//   SCAN_DIV  clock cycles each digit stays lit (1..65535)
//   LZB_EN    1 = blank leading zeros on digits 3..1, 0 = show every digit
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      synchronous active-high reset
//   LOAD       single-cycle strobe, captures DIG_IN into the pending buffer
//   DIG_IN     four BCD nibbles, [3:0] = digit0 (ones) .. [15:12] = digit3
//   BLANK      level, 1 turns the whole display off
//   SEG_OUT    segments a..g on bits 0..6, active-low
//   AN_OUT     digit enables, active-low, one-hot or all off
//   PENDING    high while loaded data waits for the frame boundary
//   FRAME_END  one-cycle pulse after the tick that ends digit3's slot
// ---------------------------------------------------------------------------
module seg7_scan4 #(
    parameter int SCAN_DIV = 1000,
    parameter bit LZB_EN   = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOAD,
    input  logic [15:0] DIG_IN,
    input  logic        BLANK,
    output logic [6:0]  SEG_OUT,
    output logic [3:0]  AN_OUT,
    output logic        PENDING,
    output logic        FRAME_END
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] prescale;
    logic [1:0]  digit_idx;
    logic [15:0] disp_reg;
    logic [15:0] pend_buf;

    logic        tick;
    logic        frame_tick;
    logic [3:0]  cur_nibble;
    logic        lz_blank;
    logic [6:0]  seg_next;
    logic [3:0]  an_next;

    // Active-low segment pattern (g..a) for one nibble; non-BCD shows "-".
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign tick       = (prescale == DIV_LAST);
    assign frame_tick = tick && (digit_idx == 2'd3);

    // Select the nibble for the current slot and decide whether it is a
    // leading zero. A digit is leading only if it and every higher digit are
    // zero; any non-BCD nibble counts as nonzero, so it stops the blanking.
    always_comb begin
        cur_nibble = 4'd0;
        lz_blank   = 1'b0;
        case (digit_idx)
            2'd0: begin
                cur_nibble = disp_reg[3:0];
                lz_blank   = 1'b0;
            end
            2'd1: begin
                cur_nibble = disp_reg[7:4];
                lz_blank   = LZB_EN && (disp_reg[15:4] == 12'd0);
            end
            2'd2: begin
                cur_nibble = disp_reg[11:8];
                lz_blank   = LZB_EN && (disp_reg[15:8] == 8'd0);
            end
            default: begin
                cur_nibble = disp_reg[15:12];
                lz_blank   = LZB_EN && (disp_reg[15:12] == 4'd0);
            end
        endcase
    end

    // Next registered output values; the blanked state drives everything off.
    always_comb begin
        seg_next = 7'h7F;
        an_next  = 4'hF;
        if (!BLANK && !lz_blank) begin
            seg_next = decode(cur_nibble);
            an_next  = ~(4'b0001 << digit_idx);
        end
    end

    // Scan timing, double buffering and registered outputs. A LOAD on the
    // boundary tick bypasses the pending buffer so the value is not left
    // waiting a full extra frame.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prescale  <= 16'd0;
            digit_idx <= 2'd0;
            disp_reg  <= 16'd0;
            pend_buf  <= 16'd0;
            PENDING   <= 1'b0;
            FRAME_END <= 1'b0;
            SEG_OUT   <= 7'h7F;
            AN_OUT    <= 4'hF;
        end else begin
            prescale <= tick ? 16'd0 : prescale + 16'd1;
            if (tick) begin
                digit_idx <= digit_idx + 2'd1;
            end
            FRAME_END <= frame_tick;

            if (LOAD) begin
                pend_buf <= DIG_IN;
            end

            if (frame_tick) begin
                if (LOAD) begin
                    disp_reg <= DIG_IN;
                end else if (PENDING) begin
                    disp_reg <= pend_buf;
                end
                PENDING <= 1'b0;
            end else if (LOAD) begin
                PENDING <= 1'b1;
            end

            SEG_OUT <= seg_next;
            AN_OUT  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan4.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan4
//
// Testbench for seg7_scan4. Two instances share the same inputs: one with
// SCAN_DIV=4 and leading-zero blanking on, one with SCAN_DIV=1 and blanking
// off. Every driven cycle the reference model computes the expected outputs
// of both instances and pushes them into per-instance queues; a monitor pops
// and compares them just after each rising edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan4;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       pend;
        logic       fe;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] din;
    logic        blank;

    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic        pend_a, pend_b;
    logic        fe_a, fe_b;

    int vectors;
    int miscompares;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state, one entry per instance.
    int div_m[2] = '{4, 1};
    bit lzb_m[2] = '{1'b1, 1'b0};
    int edges[2];
    int disp_m[2];
    int buf_m[2];
    bit pend_m[2];

    seg7_scan4 #(.SCAN_DIV(4), .LZB_EN(1'b1)) dut_a (
        .CLK(clk), .RESET(rst), .LOAD(load), .DIG_IN(din), .BLANK(blank),
        .SEG_OUT(seg_a), .AN_OUT(an_a), .PENDING(pend_a), .FRAME_END(fe_a)
    );

    seg7_scan4 #(.SCAN_DIV(1), .LZB_EN(1'b0)) dut_b (
        .CLK(clk), .RESET(rst), .LOAD(load), .DIG_IN(din), .BLANK(blank),
        .SEG_OUT(seg_b), .AN_OUT(an_b), .PENDING(pend_b), .FRAME_END(fe_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Behaviour of one instance across one rising edge, derived from the
    // number of edges since reset: slot = (edge-1)/SCAN_DIV mod 4, and a
    // frame boundary falls on every 4*SCAN_DIV-th edge.
    task automatic model_edge(input int k, input logic r, input logic l,
                              input logic [15:0] d, input logic b,
                              output exp_t x);
        int  slot;
        int  upper;
        bit  boundary;
        bit  lz;
        if (r) begin
            edges[k]  = 0;
            disp_m[k] = 0;
            buf_m[k]  = 0;
            pend_m[k] = 1'b0;
            x.seg  = 7'h7F;
            x.an   = 4'hF;
            x.pend = 1'b0;
            x.fe   = 1'b0;
        end else begin
            edges[k] = edges[k] + 1;
            slot     = ((edges[k] - 1) / div_m[k]) % 4;
            boundary = (edges[k] % (4 * div_m[k])) == 0;
            upper    = disp_m[k] >> (4 * slot);
            lz       = lzb_m[k] && (slot != 0) && (upper == 0);
            if (b || lz) begin
                x.seg = 7'h7F;
                x.an  = 4'hF;
            end else begin
                x.seg = seg_of(upper % 16);
                x.an  = 4'(4'hF ^ (1 << slot));
            end
            if (boundary) begin
                if (l) disp_m[k] = int'(d);
                else if (pend_m[k]) disp_m[k] = buf_m[k];
                pend_m[k] = 1'b0;
            end else if (l) begin
                buf_m[k]  = int'(d);
                pend_m[k] = 1'b1;
            end
            x.pend = pend_m[k];
            x.fe   = boundary;
        end
    endtask

    // Drive one cycle of inputs and queue what both instances should show.
    task automatic apply_stimulus(input logic r, input logic l,
                                  input logic [15:0] d, input logic b);
        exp_t x;
        @(negedge clk);
        rst   = r;
        load  = l;
        din   = d;
        blank = b;
        model_edge(0, r, l, d, b, x);
        q0.push_back(x);
        model_edge(1, r, l, d, b, x);
        q1.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    // Idle until the next edge of instance A is at position m in its frame.
    task automatic run_to(input int m);
        for (int i = 0; i < 64; i++) begin
            if (((edges[0] + 1) % 16) == m) break;
            apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        end
    endtask

    task automatic check_output(input string name, input exp_t act, input exp_t exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s @%0t: got seg=%h an=%h pend=%b fe=%b, expected seg=%h an=%h pend=%b fe=%b",
                     name, $time, act.seg, act.an, act.pend, act.fe,
                     exp.seg, exp.an, exp.pend, exp.fe);
        end
    endtask

    // Monitor: the outputs settle after each rising edge; pop one expected
    // entry per instance for every edge that the stimulus accounted for.
    always @(posedge clk) begin
        exp_t ea;
        exp_t eb;
        #1;
        if (q0.size() > 0) begin
            ea = q0.pop_front();
            check_output("dut_a", {seg_a, an_a, pend_a, fe_a}, ea);
        end
        if (q1.size() > 0) begin
            eb = q1.pop_front();
            check_output("dut_b", {seg_b, an_b, pend_b, fe_b}, eb);
        end
    end

    function automatic logic [15:0] rand_digits();
        int          kind;
        int          lead;
        logic [15:0] v;
        kind = $urandom_range(0, 3);
        v    = 16'h0000;
        case (kind)
            0: v = 16'($urandom);
            1: begin
                lead = $urandom_range(0, 3);
                for (int n = 0; n < 4 - lead; n++) v[n*4 +: 4] = 4'($urandom_range(0, 9));
            end
            2: v = 16'h0000;
            default: v = 16'($urandom_range(0, 15));
        endcase
        return v;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        load  = 1'b0;
        din   = 16'h0000;
        blank = 1'b0;
        edges  = '{0, 0};
        disp_m = '{0, 0};
        buf_m  = '{0, 0};
        pend_m = '{1'b0, 1'b0};

        $display("[TB] reset and idle frames");
        apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        idle(34);

        $display("[TB] load during digit1 slot");
        run_to(6);
        apply_stimulus(1'b0, 1'b1, 16'h0107, 1'b0);
        idle(24);

        $display("[TB] invalid and mixed digits");
        run_to(6);
        apply_stimulus(1'b0, 1'b1, 16'h93A5, 1'b0);
        idle(20);
        run_to(3);
        apply_stimulus(1'b0, 1'b1, 16'h0000, 1'b0);
        idle(20);

        $display("[TB] double load before boundary");
        run_to(2);
        apply_stimulus(1'b0, 1'b1, 16'h0011, 1'b0);
        apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        apply_stimulus(1'b0, 1'b1, 16'h0022, 1'b0);
        idle(20);

        $display("[TB] load on frame-end tick, then blank mid-frame");
        run_to(0);
        apply_stimulus(1'b0, 1'b1, 16'h0456, 1'b0);
        idle(18);
        run_to(7);
        for (int i = 0; i < 14; i++) apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        idle(20);

        $display("[TB] reset with data pending");
        run_to(5);
        apply_stimulus(1'b0, 1'b1, 16'h0099, 1'b0);
        idle(2);
        apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        idle(20);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 900; i++) begin
            apply_stimulus(($urandom_range(0, 199) == 0),
                           ($urandom_range(0, 7) == 0),
                           rand_digits(),
                           ($urandom_range(0, 9) == 0));
        end
        idle(4);

        @(posedge clk);
        #3;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL drain: entries left a=%0d b=%0d, expected 0",
                     q0.size(), q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
